// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with tick divider, run/stop, clear, load,
// wrap pulse and a sequential shift-and-add-3 binary-to-BCD converter.
// Handshake: bcd_valid=1 means bcd holds the decimal form of count; it drops
// on the edge after any change of count and rises COUNT_W+1 cycles after it.
module updown_counter_gen #(
    parameter int MAX_COUNT = 9999,
    parameter int DIV_COUNT = 10_000_000,
    parameter int DIGITS    = 4,
    parameter int COUNT_W   = $clog2(MAX_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  mode,
    input  logic                  clear,
    input  logic                  load,
    input  logic [COUNT_W-1:0]    load_value,
    output logic [COUNT_W-1:0]    count,
    output logic                  wrap,
    output logic                  tick_out,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid
);

    localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int BIT_W = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV_COUNT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(COUNT_W - 1);

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_e;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick_q, tick_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;

    conv_state_e        conv_state_q;
    logic [COUNT_W-1:0] count_prev_q;
    logic [COUNT_W-1:0] bin_q;
    logic [BCD_W-1:0]   sr_q;
    logic [BIT_W-1:0]   bit_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               valid_q;

    logic [BCD_W-1:0]   sr_adj;
    logic [BCD_W-1:0]   sr_shift;

    // Next-state for divider and counter: clear beats load beats a pending tick.
    always_comb begin
        div_d   = div_q;
        tick_d  = 1'b0;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            div_d   = '0;
            count_d = '0;
        end else begin
            if (run) begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            if (load) begin
                count_d = (load_value > MAX_C) ? MAX_C : load_value;
            end else if (tick_q) begin
                if (!mode) begin
                    if (count_q == MAX_C) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - COUNT_W'(1);
                    end
                end
            end
        end
    end

    // Divider and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[4*i +: 4] >= 4'd5) begin
                sr_adj[4*i +: 4] = sr_q[4*i +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[BCD_W-2:0], bin_q[COUNT_W-1]};
    end

    // Converter FSM: a count change (re)starts it; the last shift latches the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_state_q <= CONV_IDLE;
            count_prev_q <= '0;
            bin_q        <= '0;
            sr_q         <= '0;
            bit_q        <= '0;
            bcd_q        <= '0;
            valid_q      <= 1'b1;
        end else begin
            count_prev_q <= count_q;
            if (count_q != count_prev_q) begin
                conv_state_q <= CONV_SHIFT;
                bin_q        <= count_q;
                sr_q         <= '0;
                bit_q        <= '0;
                valid_q      <= 1'b0;
            end else if (conv_state_q == CONV_SHIFT) begin
                bin_q <= bin_q << 1;
                sr_q  <= sr_shift;
                bit_q <= bit_q + BIT_W'(1);
                if (bit_q == BIT_LAST) begin
                    bcd_q        <= sr_shift;
                    valid_q      <= 1'b1;
                    conv_state_q <= CONV_IDLE;
                end
            end
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign tick_out  = tick_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: directed steps followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_updown_counter_gen;

    localparam int MAX_COUNT = 99;
    localparam int DIV_COUNT = 10;
    localparam int DIGITS    = 2;
    localparam int COUNT_W   = $clog2(MAX_COUNT + 1);
    localparam int BCD_W     = 4 * DIGITS;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               mode;
    logic               clear;
    logic               load;
    logic [COUNT_W-1:0] load_value;
    logic [COUNT_W-1:0] count;
    logic               wrap;
    logic               tick_out;
    logic [BCD_W-1:0]   bcd;
    logic               bcd_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers, decimal arithmetic)
    int               m_cnt  = 0;
    int               m_prev = 0;
    int               m_div  = 0;
    int               m_left = 0;
    int               m_conv = 0;
    bit               m_tick = 1'b0;
    bit               m_wrap = 1'b0;
    bit               m_valid = 1'b1;
    logic [BCD_W-1:0] m_bcd = '0;

    updown_counter_gen #(
        .MAX_COUNT(MAX_COUNT),
        .DIV_COUNT(DIV_COUNT),
        .DIGITS   (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode      (mode),
        .clear     (clear),
        .load      (load),
        .load_value(load_value),
        .count     (count),
        .wrap      (wrap),
        .tick_out  (tick_out),
        .bcd       (bcd),
        .bcd_valid (bcd_valid)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Model update for one rising edge, using the inputs present at that edge
    task automatic model_edge();
        int nc;
        int lv;
        bit nw;
        if (!rst) begin
            m_cnt = 0; m_prev = 0; m_div = 0; m_left = 0; m_conv = 0;
            m_tick = 1'b0; m_wrap = 1'b0; m_valid = 1'b1; m_bcd = '0;
        end else begin
            if (m_cnt != m_prev) begin
                m_left  = COUNT_W;
                m_conv  = m_cnt;
                m_valid = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd   = to_bcd(m_conv);
                    m_valid = 1'b1;
                end
            end
            nc = m_cnt;
            nw = 1'b0;
            lv = int'(load_value);
            if (clear) begin
                nc = 0;
            end else if (load) begin
                nc = (lv > MAX_COUNT) ? MAX_COUNT : lv;
            end else if (m_tick) begin
                if (!mode) begin
                    nw = (m_cnt == MAX_COUNT);
                    nc = (m_cnt + 1) % (MAX_COUNT + 1);
                end else begin
                    nw = (m_cnt == 0);
                    nc = (m_cnt + MAX_COUNT) % (MAX_COUNT + 1);
                end
            end
            m_prev = m_cnt;
            m_cnt  = nc;
            m_wrap = nw;
            if (clear) begin
                m_div  = 0;
                m_tick = 1'b0;
            end else if (run) begin
                m_tick = (m_div == DIV_COUNT - 1);
                m_div  = (m_div + 1) % DIV_COUNT;
            end else begin
                m_tick = 1'b0;
            end
        end
    endtask

    // One clock: model steps on the rising edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("count",     32'(count),     32'(m_cnt));
        chk("tick_out",  32'(tick_out),  32'(m_tick));
        chk("wrap",      32'(wrap),      32'(m_wrap));
        chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
        chk("bcd",       32'(bcd),       32'(m_bcd));
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_change(input string tag, input int budget);
        logic [COUNT_W-1:0] start;
        bit seen;
        start = count;
        seen  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (count !== start) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; mode = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
        cycles(2);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_bcd",   32'(bcd),   32'h0);
        chk("reset_valid", 32'(bcd_valid), 32'd1);

        // Step 1: count up 25 ticks
        rst = 1'b1; run = 1'b1;
        cycles(251);
        chk("s1_count", 32'(count), 32'd25);
        cycles(7);
        chk("s1_valid_low", 32'(bcd_valid), 32'd0);
        cyc();
        chk("s1_bcd",   32'(bcd),       32'h25);
        chk("s1_valid", 32'(bcd_valid), 32'd1);

        // Step 2: load 98, step up through the top
        load_value = 7'd98; load = 1'b1;
        cyc();
        load = 1'b0;
        chk("s2_load", 32'(count), 32'd98);
        wait_change("s2_step1_timeout", 30);
        chk("s2_99", 32'(count), 32'd99);
        wait_change("s2_step2_timeout", 30);
        chk("s2_wrap_count", 32'(count), 32'd0);
        chk("s2_wrap_pulse", 32'(wrap),  32'd1);
        cyc();
        chk("s2_wrap_gone", 32'(wrap), 32'd0);
        cycles(7);
        chk("s2_bcd", 32'(bcd), 32'h00);
        chk("s2_valid", 32'(bcd_valid), 32'd1);

        // Step 3: count down through zero
        mode = 1'b1;
        wait_change("s3_timeout", 30);
        chk("s3_count", 32'(count), 32'd99);
        chk("s3_wrap",  32'(wrap),  32'd1);
        cycles(8);
        chk("s3_bcd", 32'(bcd), 32'h99);

        // Step 4: saturating load, then clear beats load
        load_value = 7'd5; load = 1'b1;
        cyc();
        load_value = 7'd120;
        cyc();
        load = 1'b0;
        chk("s4_saturate", 32'(count), 32'd99);
        clear = 1'b1; load = 1'b1; load_value = 7'd50;
        cyc();
        clear = 1'b0; load = 1'b0;
        chk("s4_clear_wins", 32'(count), 32'd0);
        cycles(10);
        chk("s4_div_restart_hold", 32'(count), 32'd0);
        cyc();
        chk("s4_div_restart_step", 32'(count), 32'd99);
        chk("s4_div_restart_wrap", 32'(wrap),  32'd1);

        // Step 5: freeze the divider mid-period
        cycles(3);
        run = 1'b0;
        cycles(50);
        chk("s5_frozen", 32'(count), 32'd99);
        run = 1'b1;
        cycles(6);
        chk("s5_remaining_hold", 32'(count),    32'd99);
        chk("s5_remaining_tick", 32'(tick_out), 32'd1);
        cyc();
        chk("s5_resume_step", 32'(count), 32'd98);

        // Step 6: reset during a conversion, then async glitches on rst
        load_value = 7'd37; load = 1'b1;
        cyc();
        load = 1'b0;
        cycles(3);
        chk("s6_converting", 32'(bcd_valid), 32'd0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("s6_rst_count", 32'(count),     32'd0);
        chk("s6_rst_bcd",   32'(bcd),       32'h0);
        chk("s6_rst_valid", 32'(bcd_valid), 32'd1);
        chk("s6_rst_wrap",  32'(wrap),      32'd0);
        chk("s6_rst_tick",  32'(tick_out),  32'd0);
        load_value = 7'd42; load = 1'b1;
        cyc();
        load = 1'b0;
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        cycles(3);
        chk("s6_async_ignored", 32'(count), 32'd42);
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        cycles(5);
        chk("s6_bcd42", 32'(bcd), 32'h42);
        chk("s6_valid42", 32'(bcd_valid), 32'd1);

        // Randomized phase against the model
        mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            run        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            clear      = ($urandom_range(0, 149) == 0);
            load       = ($urandom_range(0, 59) == 0);
            load_value = 7'($urandom_range(0, 127));
            rst        = ($urandom_range(0, 399) != 0);
            cyc();
        end
        rst = 1'b1; clear = 1'b0; load = 1'b0;
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
Parametrised successor to the fixed 0–9999 up/down counter. It has these pieces:
- Internal tick divider with configurable period.
- Up/down counter with configurable modulus.
- Run/stop, synchronous clear and parallel load.
- Wrap pulse.
- Sequential binary-to-BCD converter, so the FND controller can take decimal digits directly.

It sits between the board inputs and the FND controller in the counter top level.

Parameters:
- MAX_COUNT, 9999, terminal count; counter range is 0..MAX_COUNT.
- DIV_COUNT, 10_000_000, clk cycles per tick (10 Hz at 100 MHz).
- DIGITS, 4, number of BCD digits output; requires MAX_COUNT < 10^DIGITS.
- COUNT_W, $clog2(MAX_COUNT+1), derived count width; not to be overridden.
- Constraint: DIV_COUNT >= COUNT_W+2, so every BCD conversion completes between ticks.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge only)
- run  in  1  1 = divider advances; 0 = divider frozen (holds value)
- mode  in  1  0 = count up, 1 = count down
- clear  in  1  synchronous clear of count and divider
- load  in  1  synchronous load of load_value
- load_value  in  COUNT_W  value to load
- count  out  COUNT_W  current count, binary
- wrap  out  1  one-cycle pulse on wrap-around
- tick_out  out  1  divider tick (one-cycle pulse), for chaining/debug
- bcd  out  4*DIGITS  BCD of count; digit 0 = bits [3:0] (least significant)
- bcd_valid  out  1  bcd matches current count

Behaviour:
- Reset (rst==0 at an edge) sets:
  - divider 0, tick_out 0, count 0, wrap 0
  - bcd 0, bcd_valid 1, converter idle
- Divider:
  - div_cnt counts 0..DIV_COUNT-1 only while run==1.
  - On the edge where div_cnt==DIV_COUNT-1 and run==1: div_cnt <= 0 and tick_out <= 1.
  - tick_out is 0 on all other edges.
  - run==0 holds div_cnt and drives tick_out to 0 on the next edge.
- Count update priority on each edge (highest first):
  1. clear: count <= 0, div_cnt <= 0, tick_out <= 0, wrap <= 0.
  2. load: count <= min(load_value, MAX_COUNT), wrap <= 0. The divider is unaffected.
  3. tick_out==1 and mode==0:
     - count==MAX_COUNT: count <= 0, wrap <= 1.
     - otherwise: count+1, wrap <= 0.
  4. tick_out==1 and mode==1:
     - count==0: count <= MAX_COUNT, wrap <= 1.
     - otherwise: count-1, wrap <= 0.
  5. Otherwise: count holds, wrap <= 0.
- A tick already raised still steps the count even if run falls in that cycle.
- Latency: count changes one cycle after the edge that raised tick_out, i.e. every DIV_COUNT run-cycles.
- mode may change at any time; it is sampled on the step edge only.
- BCD converter (shift-and-add-3, one bit per cycle):
  - Starts on the edge following any change of count (step, load, clear).
  - On that edge bcd_valid <= 0 and the shift register is loaded with count.
  - Runs COUNT_W shift cycles, then latches into bcd and sets bcd_valid <= 1.
  - bcd_valid therefore rises COUNT_W+1 cycles after count changes.
  - bcd holds its previous value while bcd_valid==0.
  - If count changes during a conversion, the conversion aborts and restarts with the new value.
  - A load or clear that leaves count unchanged does not start a conversion.
- Reset mid-conversion or mid-divider: all state returns to reset values on that edge; no partial result is latched.

Test Plan:
Bench parameters: MAX_COUNT=99, DIV_COUNT=10, DIGITS=2 (COUNT_W=7).
1. Reset, then run=1, mode=0, 25 ticks:
   - tick_out pulses every 10 cycles; count 0→25.
   - bcd=8'h25 with bcd_valid=1 exactly 8 cycles after the last count change.
2. load_value=98, load, then up 2 ticks:
   - count 98→99→0; wrap=1 for one cycle coincident with count=0.
   - bcd=8'h00.
3. count=0, mode=1, one tick:
   - count=99, wrap=1 pulse, bcd=8'h99.
4. load_value=120:
   - count saturates to 99.
   - clear and load in the same cycle give count=0 (clear wins) and divider restarts at 0.
5. run=0 for 50 cycles mid-period:
   - No tick_out, count frozen, div_cnt held.
   - After run=1, the next tick arrives after the remaining cycles of the period only.
6. rst=0 asserted during a BCD conversion (bcd_valid=0):
   - Next edge gives count=0, bcd=0, bcd_valid=1, wrap=0, tick_out=0.
   - Asynchronous rst pulses between edges have no effect.
